// File: rtl/upc_scan_monitor.sv
// Multi-lane UPC scan decoder with per-lane theft alarms and saturating counts.
// Define UPC_ALARM_HOLD_EN to make alarms auto-clear after ALARM_HOLD cycles.
module upc_scan_monitor #(
    parameter int N_LANES    = 4,
    parameter int CNT_W      = 8,
    parameter int ALARM_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3*N_LANES-1:0]   upc,
    input  logic [N_LANES-1:0]     marked,
    input  logic [N_LANES-1:0]     scan_valid,
    input  logic                   clr,
    output logic [N_LANES-1:0]     disc,
    output logic [N_LANES-1:0]     stl,
    output logic [N_LANES-1:0]     inval,
    output logic [N_LANES-1:0]     alarm,
    output logic [CNT_W-1:0]       scan_cnt,
    output logic [CNT_W-1:0]       disc_cnt,
    output logic [CNT_W-1:0]       stl_cnt
);

    localparam int SW = CNT_W + 1;

    logic [N_LANES-1:0] dec_disc;
    logic [N_LANES-1:0] dec_exp;
    logic [N_LANES-1:0] dec_inval;
    logic [N_LANES-1:0] dec_stl;
    logic [N_LANES-1:0] theft;
    logic [SW-1:0]      n_scan;
    logic [SW-1:0]      n_disc;
    logic [SW-1:0]      n_stl;

    always_comb begin
        dec_disc  = '0;
        dec_exp   = '0;
        dec_inval = '0;
        for (int i = 0; i < N_LANES; i++) begin
            case (upc[3*i +: 3])
                3'b000:  dec_exp[i] = 1'b1;
                3'b010:  dec_inval[i] = 1'b1;
                3'b011:  dec_disc[i] = 1'b1;
                3'b100: begin
                    dec_disc[i] = 1'b1;
                    dec_exp[i]  = 1'b1;
                end
                3'b101:  dec_disc[i] = 1'b1;
                3'b110:  dec_exp[i] = 1'b1;
                3'b111:  dec_inval[i] = 1'b1;
                default: ;
            endcase
        end
        dec_stl = dec_exp & ~marked & ~dec_inval;
        theft   = scan_valid & dec_stl;
    end

    always_comb begin
        n_scan = '0;
        n_disc = '0;
        n_stl  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            n_scan = n_scan + SW'(scan_valid[i]);
            n_disc = n_disc + SW'(scan_valid[i] & dec_disc[i]);
            n_stl  = n_stl + SW'(theft[i]);
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] c,
        input logic [SW-1:0]    inc
    );
        logic [SW-1:0] s;
        s = {1'b0, c} + inc;
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disc  <= '0;
            stl   <= '0;
            inval <= '0;
        end else begin
            disc  <= (scan_valid & dec_disc)  | (~scan_valid & disc);
            stl   <= (scan_valid & dec_stl)   | (~scan_valid & stl);
            inval <= (scan_valid & dec_inval) | (~scan_valid & inval);
        end
    end

    // clr drops this cycle's increments as well as the old totals
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            disc_cnt <= '0;
            stl_cnt  <= '0;
        end else if (clr) begin
            scan_cnt <= '0;
            disc_cnt <= '0;
            stl_cnt  <= '0;
        end else begin
            scan_cnt <= sat_add(scan_cnt, n_scan);
            disc_cnt <= sat_add(disc_cnt, n_disc);
            stl_cnt  <= sat_add(stl_cnt, n_stl);
        end
    end

`ifdef UPC_ALARM_HOLD_EN
    localparam int HW = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;

    logic [HW-1:0] hold [N_LANES];

    // a new theft wins over clr and restarts the hold window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm <= '0;
            for (int i = 0; i < N_LANES; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                if (theft[i]) begin
                    alarm[i] <= 1'b1;
                    hold[i]  <= HW'(ALARM_HOLD - 1);
                end else if (clr) begin
                    alarm[i] <= 1'b0;
                end else if (alarm[i]) begin
                    if (hold[i] == '0) alarm[i] <= 1'b0;
                    else hold[i] <= hold[i] - 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alarm <= '0;
        else alarm <= theft | (alarm & ~{N_LANES{clr}});
    end
`endif

endmodule

// File: tb/tb_upc_scan_monitor.sv
// Directed vector bench for upc_scan_monitor (2 lanes, 4-bit counters).
// Also covers saturation, async reset and the alarm hold/sticky behaviour.
module tb_upc_scan_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] upc = '0;
    logic [1:0] marked = '0;
    logic [1:0] scan_valid = '0;
    logic       clr = 1'b0;
    logic [1:0] disc, stl, inval, alarm;
    logic [3:0] scan_cnt, disc_cnt, stl_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    upc_scan_monitor #(
        .N_LANES(2),
        .CNT_W(4),
        .ALARM_HOLD(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .upc(upc),
        .marked(marked),
        .scan_valid(scan_valid),
        .clr(clr),
        .disc(disc),
        .stl(stl),
        .inval(inval),
        .alarm(alarm),
        .scan_cnt(scan_cnt),
        .disc_cnt(disc_cnt),
        .stl_cnt(stl_cnt)
    );

    typedef struct {
        logic [5:0] upc;
        logic [1:0] mk;
        logic [1:0] vl;
        logic       clr;
        logic [1:0] d;
        logic [1:0] s;
        logic [1:0] iv;
        logic [1:0] al;
        logic [3:0] sc;
        logic [3:0] dc;
        logic [3:0] stc;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [19:0] outs();
        return {disc, stl, inval, alarm, scan_cnt, disc_cnt, stl_cnt};
    endfunction

    task automatic chk(input string name, input logic [19:0] act,
                       input logic [19:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] u, input logic [1:0] m,
                         input logic [1:0] v, input logic c);
        upc = u;
        marked = m;
        scan_valid = v;
        clr = c;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{6'o04, 2'b00, 2'b01, 1'b0, 2'b01, 2'b01, 2'b00, 2'b01, 4'd1,  4'd1, 4'd1};
        tbl[1]  = '{6'o00, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 4'd0,  4'd0, 4'd0};
        tbl[2]  = '{6'o33, 2'b00, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 4'd2,  4'd2, 4'd0};
        tbl[3]  = '{6'o33, 2'b00, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 4'd4,  4'd4, 4'd0};
        tbl[4]  = '{6'o33, 2'b00, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 4'd6,  4'd6, 4'd0};
        tbl[5]  = '{6'o67, 2'b10, 2'b11, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd8,  4'd6, 4'd0};
        tbl[6]  = '{6'o04, 2'b00, 2'b10, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 4'd9,  4'd6, 4'd1};
        tbl[7]  = '{6'o06, 2'b00, 2'b01, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11, 4'd10, 4'd6, 4'd2};
        tbl[8]  = '{6'o07, 2'b00, 2'b01, 1'b0, 2'b00, 2'b10, 2'b01, 2'b11, 4'd11, 4'd6, 4'd2};
        tbl[9]  = '{6'o00, 2'b00, 2'b10, 1'b1, 2'b00, 2'b10, 2'b01, 2'b10, 4'd0,  4'd0, 4'd0};
        tbl[10] = '{6'o55, 2'b11, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 4'd2,  4'd2, 4'd0};
        tbl[11] = '{6'o01, 2'b00, 2'b01, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 4'd3,  4'd2, 4'd0};
        tbl[12] = '{6'o44, 2'b11, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 4'd5,  4'd4, 4'd0};
`ifdef UPC_ALARM_HOLD_EN
        tbl[12].al = 2'b00;
`endif

        #3;
        chk("reset_state", outs(), 20'h0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].upc, tbl[i].mk, tbl[i].vl, tbl[i].clr);
            cyc();
            chk($sformatf("vec%0d", i), outs(),
                {tbl[i].d, tbl[i].s, tbl[i].iv, tbl[i].al,
                 tbl[i].sc, tbl[i].dc, tbl[i].stc});
        end

        // saturation at 15 with no wrap, then clr
        drive(6'o00, 2'b00, 2'b00, 1'b1);
        cyc();
        for (int k = 1; k <= 20; k++) begin
            drive(6'o01, 2'b00, 2'b01, 1'b0);
            cyc();
            chk($sformatf("sat%0d", k), {16'h0, scan_cnt},
                {16'h0, (k > 15) ? 4'd15 : 4'(k)});
        end
        drive(6'o00, 2'b00, 2'b00, 1'b1);
        cyc();
        chk("sat_clr", {16'h0, scan_cnt}, 20'h0);

`ifdef UPC_ALARM_HOLD_EN
        begin
            logic [5:0] e1;
            logic [5:0] e2;
            e1 = 6'b000111;
            e2 = 6'b011111;
            drive(6'o00, 2'b00, 2'b01, 1'b0);
            for (int k = 0; k < 6; k++) begin
                cyc();
                drive(6'o00, 2'b00, 2'b00, 1'b0);
                chk($sformatf("hold1_%0d", k), {19'h0, alarm[0]},
                    {19'h0, e1[k]});
            end
            drive(6'o00, 2'b00, 2'b01, 1'b0);
            for (int k = 0; k < 6; k++) begin
                cyc();
                drive(6'o00, 2'b00, (k == 1) ? 2'b01 : 2'b00, 1'b0);
                chk($sformatf("hold2_%0d", k), {19'h0, alarm[0]},
                    {19'h0, e2[k]});
            end
        end
`else
        drive(6'o00, 2'b00, 2'b01, 1'b0);
        cyc();
        drive(6'o00, 2'b00, 2'b00, 1'b0);
        repeat (8) cyc();
        chk("sticky", {18'h0, alarm}, 20'h1);
        drive(6'o00, 2'b00, 2'b00, 1'b1);
        cyc();
        chk("sticky_clr", {18'h0, alarm}, 20'h0);
`endif

        // async reset mid-cycle while both alarms are up
        drive(6'o00, 2'b00, 2'b11, 1'b0);
        cyc();
        chk("pre_rst", {18'h0, alarm}, 20'h3);
        drive(6'o00, 2'b00, 2'b00, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", outs(), 20'h0);
        #1 rst_n = 1'b1;
        drive(6'o02, 2'b00, 2'b01, 1'b0);
        cyc();
        chk("post_rst", outs(), {2'b00, 2'b00, 2'b01, 2'b00,
                                 4'd1, 4'd0, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/upc_scan_monitor.md
UPC_SCAN_MONITOR -- requirements
Module: upc_scan_monitor

Interface
REQ-001 The block SHALL have parameter N_LANES, default 4: number of independent scan lanes, 1..8.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of each aggregate event counter.
REQ-003 The block SHALL have parameter ALARM_HOLD, default 16: auto-clear hold time in cycles, used only under UPC_ALARM_HOLD_EN.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge, except on reset.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 upc  in  3*N_LANES  per lane {U,P,C}; lane i occupies bits [3i+2:3i].
REQ-007 marked  in  N_LANES  per lane: item carries a paid/security mark.
REQ-008 scan_valid  in  N_LANES  per lane: upc and marked are valid this cycle.
REQ-009 clr  in  1  synchronous clear of counters and alarms.
REQ-010 disc  out  N_LANES  registered: last scanned item is discounted.
REQ-011 stl  out  N_LANES  registered: last scanned item is stolen.
REQ-012 inval  out  N_LANES  registered: last scanned code is unassigned.
REQ-013 alarm  out  N_LANES  per-lane theft alarm.
REQ-014 scan_cnt, disc_cnt, stl_cnt  out  CNT_W each  saturating aggregate counts.

Function
REQ-015 Decode SHALL be: disc set for codes 011, 100, 101; expensive set for codes 000, 100, 110; inval set for codes 010, 111; stolen SHALL equal expensive AND NOT marked AND NOT inval.
REQ-016 On a lane with scan_valid=1 in cycle t, disc/stl/inval for that lane SHALL reflect the decode in cycle t+1 and hold until that lane's next valid scan.
REQ-017 A lane with scan_valid=0 SHALL leave its disc/stl/inval unchanged.
REQ-018 Each cycle, scan_cnt SHALL add the number of lanes with valid scans; disc_cnt SHALL add the number of valid scans that decode disc; stl_cnt SHALL add the number of valid scans that decode stolen.
REQ-019 Counter sums SHALL be computed in CNT_W+1 bits and saturate at 2^CNT_W-1; a counter SHALL never wrap.
REQ-020 An invalid code SHALL increment scan_cnt only.
REQ-021 A valid stolen scan on lane i SHALL set alarm[i] in cycle t+1.
REQ-022 clr=1 SHALL zero all counters in the next cycle and drop that cycle's counter increments.
REQ-023 clr=1 SHALL clear all alarms, except that a lane with a stolen scan in the same cycle SHALL have its alarm set; setting has priority over clearing.
REQ-024 clr SHALL NOT affect disc, stl or inval.

Reset
REQ-025 While rst_n=0, disc, stl, inval, alarm and all counters SHALL be 0 immediately, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard in-flight scans; the first valid scan after rst_n rises SHALL be counted normally.

Configuration
REQ-027 With UPC_ALARM_HOLD_EN defined, each lane SHALL have a hold counter that loads ALARM_HOLD-1 when the alarm sets or re-sets; alarm[i] SHALL clear on the cycle after the counter reaches 0 with no new theft; a repeated theft SHALL restart the hold.
REQ-028 With UPC_ALARM_HOLD_EN undefined, alarms SHALL be sticky until clr or reset, and no hold-counter logic SHALL be present.

Verification
REQ-029 N_LANES=2: lane0 upc=100, marked=0, valid=1 -> next cycle stl[0]=1, disc[0]=1, alarm[0]=1, scan_cnt=1, disc_cnt=1, stl_cnt=1.
REQ-030 Both lanes valid with upc=011 for 3 cycles -> scan_cnt=6, disc_cnt=6, stl_cnt=0, alarm=00.
REQ-031 CNT_W=4: 20 valid scans on 1 lane -> scan_cnt holds at 15 with no wrap; clr -> scan_cnt=0 next cycle.
REQ-032 clr=1 in the same cycle as a lane1 scan upc=000, marked=0 -> counters=0 and alarm[1]=1 next cycle.
REQ-033 UPC_ALARM_HOLD_EN, ALARM_HOLD=3: single theft -> alarm high exactly 3 cycles; second theft at cycle 2 -> alarm high until cycle 5.
REQ-034 rst_n pulsed low between clock edges while alarm=11 -> all outputs 0 immediately; upc=010 scan afterwards -> inval=1, scan_cnt=1, stl=0.
